// File: rtl/ram_arbiter_wb.sv
// ram_arbiter_wb: shares the RAM port between the CPU Wishbone master and the
// disk-copy DMA engine, with a bounded DMA burst and an ack timeout.
// Ports: cpu_* Wishbone slave side, dma_* copy-engine strobe side,
// mem_* RAM master side, cpu_wait_o DMA-active status, err_o timeout pulse.
module ram_arbiter_wb #(
    parameter int DMA_BURST = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    input  logic [1:0]  cpu_sel_i,
    input  logic [24:0] cpu_adr_i,
    input  logic [15:0] cpu_dat_i,
    output logic [15:0] cpu_dat_o,
    output logic        cpu_ack_o,
    input  logic        dma_rd_i,
    input  logic        dma_we_i,
    input  logic [24:0] dma_adr_i,
    input  logic [15:0] dma_dat_i,
    output logic [15:0] dma_dat_o,
    output logic        dma_ack_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_sel_o,
    output logic [24:0] mem_adr_o,
    output logic [15:0] mem_dat_o,
    input  logic [15:0] mem_dat_i,
    input  logic        mem_ack_i,
    output logic        cpu_wait_o,
    output logic        err_o
);

    localparam logic [7:0] BURST_MAX = 8'(DMA_BURST);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner_dma;
    logic        dma_pend;
    logic        dma_we;
    logic [24:0] dma_adr;
    logic [15:0] dma_wdat;
    logic        cpu_done;
    logic [7:0]  burst_cnt;
    logic [7:0]  to_cnt;
    logic        cpu_req;
    logic        arb_ok;
    logic        grant_dma;
    logic        grant_cpu;
    logic        to_hit;
    logic        done;
    logic [15:0] rd_word;

    assign cpu_req    = cpu_cyc_i & cpu_stb_i & ~cpu_done;
    assign cpu_wait_o = dma_pend | ((state == BUSY) & owner_dma);
    assign rd_word    = mem_ack_i ? mem_dat_i : 16'hFFFF;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (grant_cpu | grant_dma) state_nxt = BUSY;
            BUSY: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration is skipped in the ack cycle: the CPU gets time to drop
    // its strobe and the copy engine gets time to re-strobe.
    always_comb begin
        arb_ok    = 1'b0;
        grant_dma = 1'b0;
        grant_cpu = 1'b0;
        to_hit    = 1'b0;
        done      = 1'b0;
        if (state == IDLE) begin
            arb_ok    = ~(cpu_ack_o | dma_ack_o);
            grant_dma = arb_ok & dma_pend &
                        (~cpu_req | (burst_cnt != BURST_MAX));
            grant_cpu = arb_ok & cpu_req & ~grant_dma;
        end else begin
            to_hit = (to_cnt == TO_LAST);
            done   = mem_ack_i | to_hit;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            owner_dma <= 1'b0;
            dma_pend  <= 1'b0;
            dma_we    <= 1'b0;
            dma_adr   <= '0;
            dma_wdat  <= '0;
            cpu_done  <= 1'b0;
            burst_cnt <= '0;
            to_cnt    <= '0;
            cpu_dat_o <= '0;
            cpu_ack_o <= 1'b0;
            dma_dat_o <= '0;
            dma_ack_o <= 1'b0;
            mem_stb_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_sel_o <= '0;
            mem_adr_o <= '0;
            mem_dat_o <= '0;
            err_o     <= 1'b0;
        end else begin
            cpu_ack_o <= 1'b0;
            dma_ack_o <= 1'b0;
            err_o     <= 1'b0;

            // A grant needs dma_pend set, so capture and clear never collide.
            if (!dma_pend && (dma_rd_i || dma_we_i)) begin
                dma_pend <= 1'b1;
                dma_we   <= dma_we_i;
                dma_adr  <= dma_adr_i;
                dma_wdat <= dma_dat_i;
            end else if (grant_dma) begin
                dma_pend <= 1'b0;
            end

            if (!cpu_stb_i)     cpu_done <= 1'b0;
            else if (cpu_ack_o) cpu_done <= 1'b1;

            if (grant_cpu || !cpu_req) burst_cnt <= '0;
            else if (grant_dma)        burst_cnt <= burst_cnt + 8'd1;

            if (grant_cpu) begin
                owner_dma <= 1'b0;
                mem_stb_o <= 1'b1;
                mem_we_o  <= cpu_we_i;
                mem_sel_o <= cpu_sel_i;
                mem_adr_o <= cpu_adr_i;
                mem_dat_o <= cpu_dat_i;
                to_cnt    <= '0;
            end else if (grant_dma) begin
                owner_dma <= 1'b1;
                mem_stb_o <= 1'b1;
                mem_we_o  <= dma_we;
                mem_sel_o <= 2'b11;
                mem_adr_o <= dma_adr;
                mem_dat_o <= dma_wdat;
                to_cnt    <= '0;
            end else if (state == BUSY) begin
                to_cnt <= to_cnt + 8'd1;
                if (done) begin
                    mem_stb_o <= 1'b0;
                    err_o     <= ~mem_ack_i;
                    if (owner_dma) begin
                        dma_ack_o <= 1'b1;
                        if (!mem_we_o) dma_dat_o <= rd_word;
                    end else begin
                        cpu_ack_o <= 1'b1;
                        if (!mem_we_o) cpu_dat_o <= rd_word;
                    end
                end
            end
        end
    end

endmodule
